// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM control unit: FSM states, instruction classes,
// shift-amount source selects and the compare-only opcode test.
package ctrl_pkg;

    localparam int unsigned ST_W  = 3;
    localparam int unsigned CLS_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [ST_W-1:0] ST_DECODE = 3'd2;
    localparam logic [ST_W-1:0] ST_EXEC   = 3'd3;
    localparam logic [ST_W-1:0] ST_WB     = 3'd4;
    localparam logic [ST_W-1:0] ST_MEM    = 3'd5;
    localparam logic [ST_W-1:0] ST_LDWB   = 3'd6;

    localparam logic [CLS_W-1:0] CLS_DP0 = 3'd0;
    localparam logic [CLS_W-1:0] CLS_DP1 = 3'd1;
    localparam logic [CLS_W-1:0] CLS_DP2 = 3'd2;
    localparam logic [CLS_W-1:0] CLS_LS  = 3'd3;
    localparam logic [CLS_W-1:0] CLS_UND = 3'd4;

    localparam logic [1:0] RS_IMM5 = 2'b00;
    localparam logic [1:0] RS_REG  = 2'b01;
    localparam logic [1:0] RS_ROT  = 2'b10;

    // TST/TEQ/CMP/CMN (10xx) only set flags; every other opcode writes rd
    function automatic logic op_writes_rd(input logic [3:0] op);
        return !op[3] | op[2];
    endfunction

endpackage

// File: rtl/inst_class_dec.sv
// Combinational instruction classifier: IR[27:0] -> DP0/DP1/DP2/LS/UND.
module inst_class_dec
    import ctrl_pkg::*;
(
    input  logic [27:0] IR,
    output logic [2:0]  cls_c
);

    logic unused_ir;
    assign unused_ir = ^{IR[24:16], IR[11:8], IR[6:5], IR[3:0]};

    // rd==PC is never supported, so it overrides every other encoding
    always_comb begin
        cls_c = CLS_UND;
        if (IR[15:12] == 4'hF) begin
            cls_c = CLS_UND;
        end else if (IR[27:25] == 3'b000) begin
            if (!IR[4])      cls_c = CLS_DP0;
            else if (!IR[7]) cls_c = CLS_DP1;
        end else if (IR[27:25] == 3'b001) begin
            cls_c = CLS_DP2;
        end else if (IR[27:25] == 3'b010) begin
            cls_c = CLS_LS;
        end
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM for the ARM datapath: DP sequencing plus LDR/STR over req/ack memory.
// Optional CTRL_PERF_EN adds cycle / retired-instruction counters.
module mc_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TO = 15,
    parameter int unsigned TO_W   = 4
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [27:0] IR,
    input  logic        cond_pass,
    input  logic        mem_ack,
    output logic        Write_PC,
    output logic        Write_IR,
    output logic        LA,
    output logic        LB,
    output logic        LC,
    output logic        LF,
    output logic        S,
    output logic        rm_imm_s,
    output logic [1:0]  rs_imm_s,
    output logic        ls_mode,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ld_mdr,
    output logic        reg_src,
    output logic        Write_Reg,
    output logic        und_pulse,
    output logic        mem_err,
    output logic [31:0] cyc_cnt,
    output logic [31:0] inst_cnt
);

    logic [ST_W-1:0]  st, nxt_st;
    logic [CLS_W-1:0] cls;
    logic [TO_W-1:0]  to_cnt, to_cnt_inc;
    logic             is_dp, is_und, timeout, retire;

    logic write_pc_d, write_ir_d, la_d, lb_d, lc_d, lf_d, s_d, rm_imm_s_d;
    logic [1:0] rs_imm_s_d;
    logic ls_mode_d, mem_req_d, mem_we_d, ld_mdr_d, reg_src_d, write_reg_d, und_d, err_d;

    inst_class_dec u_dec (
        .IR    (IR),
        .cls_c (cls)
    );

    assign is_und = (cls == CLS_UND);
    assign is_dp  = (cls == CLS_DP0) || (cls == CLS_DP1) || (cls == CLS_DP2);

    // Count reflects MEM cycles including the current one; saturates at MEM_TO
    assign to_cnt_inc = (to_cnt == TO_W'(MEM_TO)) ? to_cnt : to_cnt + TO_W'(1);
    assign timeout    = (to_cnt_inc == TO_W'(MEM_TO));

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) st <= ST_IDLE;
        else     st <= nxt_st;
    end

    always_comb begin
        nxt_st      = ST_FETCH;
        write_pc_d  = 1'b0;
        write_ir_d  = 1'b0;
        la_d        = 1'b0;
        lb_d        = 1'b0;
        lc_d        = 1'b0;
        lf_d        = 1'b0;
        s_d         = 1'b0;
        rm_imm_s_d  = 1'b0;
        rs_imm_s_d  = RS_IMM5;
        ls_mode_d   = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        ld_mdr_d    = 1'b0;
        reg_src_d   = 1'b0;
        write_reg_d = 1'b0;
        und_d       = 1'b0;
        err_d       = 1'b0;
        retire      = 1'b0;

        case (st)
            ST_IDLE:   nxt_st = ST_FETCH;
            ST_FETCH: begin
                if (is_und) begin
                    nxt_st = ST_FETCH;
                    und_d  = 1'b1;
                end else if (cond_pass) begin
                    nxt_st = ST_DECODE;
                end
            end
            ST_DECODE: nxt_st = ST_EXEC;
            ST_EXEC: begin
                if (cls == CLS_LS) nxt_st = ST_MEM;
                else if (is_dp)    nxt_st = ST_WB;
            end
            ST_WB:     retire = 1'b1;
            ST_MEM: begin
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    nxt_st = IR[20] ? ST_LDWB : ST_FETCH;
                    retire = !IR[20];
                end else if (timeout) begin
                    err_d  = 1'b1;
                end else begin
                    nxt_st = ST_MEM;
                end
            end
            ST_LDWB:   retire = 1'b1;
            default:   nxt_st = ST_FETCH;
        endcase

        // Outputs decoded from the state being entered so they hold for the whole state
        case (nxt_st)
            ST_FETCH: begin
                write_pc_d = 1'b1;
                write_ir_d = 1'b1;
            end
            ST_DECODE: begin
                la_d = 1'b1;
                lb_d = 1'b1;
                lc_d = 1'b1;
            end
            ST_EXEC: begin
                lf_d = 1'b1;
                if (is_dp) begin
                    s_d        = IR[20];
                    rm_imm_s_d = (cls == CLS_DP2);
                    rs_imm_s_d = (cls == CLS_DP2) ? RS_ROT :
                                 (cls == CLS_DP1) ? RS_REG : RS_IMM5;
                end else begin
                    ls_mode_d = 1'b1;
                end
            end
            ST_WB:   write_reg_d = op_writes_rd(IR[24:21]);
            ST_MEM: begin
                mem_req_d = 1'b1;
                mem_we_d  = !IR[20];
                ld_mdr_d  = IR[20];
            end
            ST_LDWB: begin
                write_reg_d = 1'b1;
                reg_src_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            to_cnt    <= '0;
            Write_PC  <= 1'b0;
            Write_IR  <= 1'b0;
            LA        <= 1'b0;
            LB        <= 1'b0;
            LC        <= 1'b0;
            LF        <= 1'b0;
            S         <= 1'b0;
            rm_imm_s  <= 1'b0;
            rs_imm_s  <= RS_IMM5;
            ls_mode   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            ld_mdr    <= 1'b0;
            reg_src   <= 1'b0;
            Write_Reg <= 1'b0;
            und_pulse <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            if (st == ST_MEM)          to_cnt <= to_cnt_inc;
            else if (nxt_st == ST_MEM) to_cnt <= '0;
            Write_PC  <= write_pc_d;
            Write_IR  <= write_ir_d;
            LA        <= la_d;
            LB        <= lb_d;
            LC        <= lc_d;
            LF        <= lf_d;
            S         <= s_d;
            rm_imm_s  <= rm_imm_s_d;
            rs_imm_s  <= rs_imm_s_d;
            ls_mode   <= ls_mode_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            ld_mdr    <= ld_mdr_d;
            reg_src   <= reg_src_d;
            Write_Reg <= write_reg_d;
            und_pulse <= und_d;
            mem_err   <= err_d;
        end
    end

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign cyc_cnt       = '0;
    assign inst_cnt      = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: directed ARM instructions plus randomized IR/cond/ack timing
// checked per instruction against a cycle/event model derived from the instruction rules.
`timescale 1ns/1ps
module tb_mc_ctrl_unit;

    localparam int unsigned MEM_TO = 15;
    localparam int unsigned TO_W   = 4;
    localparam int K_DP0 = 0, K_DP1 = 1, K_DP2 = 2, K_LS = 3, K_UND = 4;

    logic        clk = 1'b0;
    logic        Rst;
    logic [27:0] IR;
    logic        cond_pass, mem_ack;
    logic        Write_PC, Write_IR, LA, LB, LC, LF, S, rm_imm_s;
    logic [1:0]  rs_imm_s;
    logic        ls_mode, mem_req, mem_we, ld_mdr, reg_src, Write_Reg, und_pulse, mem_err;
    logic [31:0] cyc_cnt, inst_cnt;

    int n_chk = 0;
    int n_err = 0;

`ifdef CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    mc_ctrl_unit #(.MEM_TO(MEM_TO), .TO_W(TO_W)) dut (
        .clk(clk), .Rst(Rst), .IR(IR), .cond_pass(cond_pass), .mem_ack(mem_ack),
        .Write_PC(Write_PC), .Write_IR(Write_IR), .LA(LA), .LB(LB), .LC(LC), .LF(LF),
        .S(S), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .ls_mode(ls_mode),
        .mem_req(mem_req), .mem_we(mem_we), .ld_mdr(ld_mdr), .reg_src(reg_src),
        .Write_Reg(Write_Reg), .und_pulse(und_pulse), .mem_err(mem_err),
        .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    logic [17:0] out_vec;
    assign out_vec = {Write_PC, Write_IR, LA, LB, LC, LF, S, rm_imm_s, rs_imm_s, ls_mode,
                      mem_req, mem_we, ld_mdr, reg_src, Write_Reg, und_pulse, mem_err};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int classify(input logic [27:0] ir);
        if (ir[15:12] == 4'hF)                       return K_UND;
        if (ir[27:25] == 3'b000 && !ir[4])           return K_DP0;
        if (ir[27:25] == 3'b000 && ir[4] && !ir[7])  return K_DP1;
        if (ir[27:25] == 3'b001)                     return K_DP2;
        if (ir[27:26] == 2'b01 && !ir[25])           return K_LS;
        return K_UND;
    endfunction

    function automatic logic [27:0] gen_ir(input int kind);
        logic [27:0] ir;
        ir = 28'($urandom);
        case (kind)
            0: begin ir[27:25] = 3'b000; ir[4] = 1'b0; end
            1: begin ir[27:25] = 3'b000; ir[4] = 1'b1; ir[7] = 1'b0; end
            2: ir[27:25] = 3'b001;
            3: ir[27:25] = 3'b010;
            4: begin ir[27:25] = 3'b000; ir[4] = 1'b1; ir[7] = 1'b1; end
            5: ir[27:25] = 3'b011;
            default: ir[27] = 1'b1;
        endcase
        if ($urandom_range(7) == 0) ir[15:12] = 4'hF;
        return ir;
    endfunction

    task automatic wait_fetch(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Write_PC && n < 20);
    endtask

    // Entered at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
    // ack_at: MEM cycle (1-based) in which mem_ack is driven; 0 = never.
    task automatic run_instr(input string tag, input logic [27:0] ir, input logic cp,
                             input int ack_at);
        int cyc = 1, wr = 0, src = 0, memc = 0, we = 0, mdr = 0, s_n = 0, ls_n = 0;
        int und_n = 0, err_n = 0, rm_x = 0, rs_x = 0;
        int e_cyc = 1, e_wr = 0, e_src = 0, e_mem = 0, e_we = 0, e_mdr = 0, e_s = 0, e_ls = 0;
        int e_und = 0, e_err = 0, e_ret = 0, e_rm = 0, e_rs = 0, cls, op;
        bit done = 0, load;
        logic [31:0] c0, i0;

        c0 = cyc_cnt;
        i0 = inst_cnt;
        IR = ir;
        cond_pass = cp;
        mem_ack = 1'b0;
        while (!done && cyc <= 40) begin
            @(negedge clk);
            mem_ack = 1'b0;
            und_n += int'(und_pulse);
            err_n += int'(mem_err);
            if (Write_PC) begin
                done = 1;
            end else begin
                cyc++;
                wr   += int'(Write_Reg);
                src  += int'(reg_src);
                s_n  += int'(S);
                ls_n += int'(ls_mode);
                if (LF) begin
                    rm_x = int'(rm_imm_s);
                    rs_x = int'(rs_imm_s);
                end
                if (mem_req) begin
                    memc++;
                    we  += int'(mem_we);
                    mdr += int'(ld_mdr);
                    if (memc == ack_at) mem_ack = 1'b1;
                end
            end
        end

        cls  = classify(ir);
        op   = int'(ir[24:21]);
        load = ir[20];
        if (cls == K_UND) begin
            e_und = 1;
        end else if (cp) begin
            if (cls != K_LS) begin
                e_cyc = 4;
                e_wr  = (op >= 8 && op <= 11) ? 0 : 1;
                e_s   = int'(ir[20]);
                e_ret = 1;
                e_rm  = (cls == K_DP2) ? 1 : 0;
                e_rs  = (cls == K_DP2) ? 2 : (cls == K_DP1) ? 1 : 0;
            end else begin
                e_ls = 1;
                if (ack_at >= 1 && ack_at <= int'(MEM_TO)) begin
                    e_mem = ack_at;
                    e_ret = 1;
                    e_cyc = load ? 4 + ack_at : 3 + ack_at;
                    e_wr  = int'(load);
                    e_src = int'(load);
                end else begin
                    e_mem = int'(MEM_TO);
                    e_err = 1;
                    e_cyc = 3 + int'(MEM_TO);
                end
                e_we  = load ? 0 : e_mem;
                e_mdr = load ? e_mem : 0;
            end
        end

        chk($sformatf("%s.done", tag),   int'(done), 1);
        chk($sformatf("%s.cycles", tag), cyc, e_cyc);
        chk($sformatf("%s.wr_reg", tag), wr, e_wr);
        chk($sformatf("%s.reg_src", tag), src, e_src);
        chk($sformatf("%s.mem_cyc", tag), memc, e_mem);
        chk($sformatf("%s.mem_we", tag), we, e_we);
        chk($sformatf("%s.ld_mdr", tag), mdr, e_mdr);
        chk($sformatf("%s.S", tag), s_n, e_s);
        chk($sformatf("%s.ls_mode", tag), ls_n, e_ls);
        chk($sformatf("%s.rm_imm_s", tag), rm_x, e_rm);
        chk($sformatf("%s.rs_imm_s", tag), rs_x, e_rs);
        chk($sformatf("%s.und", tag), und_n, e_und);
        chk($sformatf("%s.mem_err", tag), err_n, e_err);
        chk($sformatf("%s.inst_cnt", tag), int'(inst_cnt - i0), PERF ? e_ret : 0);
        chk($sformatf("%s.cyc_cnt", tag), int'(cyc_cnt - c0), PERF ? e_cyc : 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ack_at, r;
        logic [27:0] ir;

        Rst = 1'b1;
        IR = '0;
        cond_pass = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", int'(out_vec), 0);
        chk("rst_cyc_cnt", int'(cyc_cnt), 0);
        chk("rst_inst_cnt", int'(inst_cnt), 0);
        Rst = 1'b0;
        wait_fetch(n);
        chk("rst_to_fetch", n, 1);
        chk("fetch_outputs", int'(out_vec), int'(18'h30000));

        run_instr("add", 28'h0821003, 1'b1, 0);
        run_instr("cmp_imm", 28'h3510005, 1'b1, 0);
        run_instr("ldr_ack4", 28'h5954008, 1'b1, 4);
        run_instr("str_noack", 28'h5054004, 1'b1, 0);
        run_instr("und_rd15", 28'h08FF003, 1'b1, 0);
        run_instr("cond_fail", 28'h0821003, 1'b0, 0);
        run_instr("ldr_ack_at_to", 28'h5954008, 1'b1, int'(MEM_TO));
        run_instr("str_ack1", 28'h5054004, 1'b1, 1);

        for (int i = 0; i < 150; i++) begin
            ir = gen_ir(int'($urandom_range(6)));
            r  = int'($urandom_range(5));
            ack_at = (r == 0) ? 0 : (r == 1) ? int'(MEM_TO) : (r == 2) ? int'(MEM_TO) - 1 :
                     int'($urandom_range(1, 4));
            run_instr($sformatf("rnd%0d", i), ir, ($urandom_range(5) != 0), ack_at);
        end

        // Reset while stalled in MEM: outputs must clear asynchronously
        IR = 28'h5954008;
        cond_pass = 1'b1;
        mem_ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        chk("mid_mem_reached", int'(mem_req), 1);
        @(negedge clk);
        #2 Rst = 1'b1;
        #1 chk("mid_mem_rst_outputs", int'(out_vec), 0);
        chk("mid_mem_rst_inst_cnt", int'(inst_cnt), 0);
        @(negedge clk);
        Rst = 1'b0;
        wait_fetch(n);
        chk("rerst_to_fetch", n, 1);

        for (int i = 0; i < 3; i++) run_instr($sformatf("dp_cnt%0d", i), 28'h0821003, 1'b1, 0);
        chk("inst_cnt_3dp", int'(inst_cnt), PERF ? 3 : 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
